// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage sequencer that sits in front of the multicycle divider.
// It latches a divide request, pulses the divider start, holds the operands stable,
// stalls the pipeline, and captures the first valid divider result for writeback.
//
// Build option: DIV_TIMEOUT_EN adds a WAIT-state watchdog that forces a faulted
// completion after TIMEOUT_CYCLES cycles without div_rdy. Without it, timeout is tied 0.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   start, dividend_in,
//   divisor_in, rd_in        divide request from the pipeline
//   flush                    kill the in-flight op
//   busy                     pipeline stall request
//   ctrl_div, div_A, div_B   divider start pulse and held operands
//   div_rdy, div_exc,
//   div_result               divider handshake and result
//   done, result, exception,
//   rd_out, timeout          writeback pulse and latched completion data
module div_issue_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned REG_BITS       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    dividend_in,
  input  logic [WIDTH-1:0]    divisor_in,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic                flush,
  output logic                busy,
  output logic                ctrl_div,
  output logic [WIDTH-1:0]    div_A,
  output logic [WIDTH-1:0]    div_B,
  input  logic                div_rdy,
  input  logic                div_exc,
  input  logic [WIDTH-1:0]    div_result,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                exception,
  output logic [REG_BITS-1:0] rd_out,
  output logic                timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero watchdog limit would make WAIT meaningless.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("div_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_expire;
  logic [WIDTH-1:0]      r_div_a;
  logic [WIDTH-1:0]      r_div_b;
  logic [REG_BITS-1:0]   r_rd;
  logic [WIDTH-1:0]      r_result;
  logic                  r_exc;
  logic [REG_BITS-1:0]   r_rd_out;

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_timeout;
`endif

  // New requests are taken only when the pipeline is not stalled; flush always wins.
  assign w_accept  = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Only the first rdy in WAIT counts; rdy during ISSUE is stale from the previous run.
  assign w_capture = (r_state == S_WAIT) && !flush && div_rdy;

`ifdef DIV_TIMEOUT_EN
  assign w_expire = (r_state == S_WAIT) && !flush && !div_rdy &&
                    (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (flush)                      w_next = S_IDLE;
        else if (w_capture || w_expire) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = w_accept ? S_ISSUE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs decoded from the state register.
  always_comb begin
    busy     = 1'b0;
    ctrl_div = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_ISSUE: begin
        busy     = 1'b1;
        ctrl_div = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch and writeback capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div_a  <= '0;
      r_div_b  <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_div_a <= dividend_in;
        r_div_b <= divisor_in;
        r_rd    <= rd_in;
      end
      if (w_capture) begin
        r_result <= div_result;
        r_exc    <= div_exc;
        r_rd_out <= r_rd;
      end else if (w_expire) begin
        r_result <= '0;
        r_exc    <= 1'b1;
        r_rd_out <= r_rd;
      end
    end
  end

`ifdef DIV_TIMEOUT_EN
  // Watchdog: cleared outside WAIT, so it restarts from 0 on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_wait_cnt <= '0;
      else                   r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_capture)     r_timeout <= 1'b0;
      else if (w_expire) r_timeout <= 1'b1;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign div_A     = r_div_a;
  assign div_B     = r_div_b;
  assign result    = r_result;
  assign exception = r_exc;
  assign rd_out    = r_rd_out;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: a behavioural divider stub drives the handshake,
// expected completions are queued on acceptance and compared when done pulses.
module tb_div_issue_ctrl;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 5;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [WIDTH-1:0]    dividend_in;
  logic [WIDTH-1:0]    divisor_in;
  logic [REG_BITS-1:0] rd_in;
  logic                flush;
  logic                busy;
  logic                ctrl_div;
  logic [WIDTH-1:0]    div_A;
  logic [WIDTH-1:0]    div_B;
  logic                div_rdy;
  logic                div_exc;
  logic [WIDTH-1:0]    div_result;
  logic                done;
  logic [WIDTH-1:0]    result;
  logic                exception;
  logic [REG_BITS-1:0] rd_out;
  logic                timeout;

  div_issue_ctrl #(.WIDTH(WIDTH), .REG_BITS(REG_BITS), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dividend_in(dividend_in),
    .divisor_in(divisor_in), .rd_in(rd_in), .flush(flush), .busy(busy),
    .ctrl_div(ctrl_div), .div_A(div_A), .div_B(div_B), .div_rdy(div_rdy),
    .div_exc(div_exc), .div_result(div_result), .done(done), .result(result),
    .exception(exception), .rd_out(rd_out), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]    res;
    logic                exc;
    logic [REG_BITS-1:0] rd;
    logic                to;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Divider stub: fixed latency after ctrl_div, rdy stays high afterwards (stale
  // re-pulse), divide-by-zero answers combinationally with an exception.
  int          lat = 4;
  bit          stub = 1'b0;
  int          m_cnt = 0;
  bit          m_active = 1'b0;
  logic [31:0] m_q = '0;

  always @(posedge clk) begin
    if (ctrl_div) begin
      m_active <= 1'b1;
      m_cnt    <= lat;
      if (div_B != 0) m_q <= $signed(div_A) / $signed(div_B);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    div_rdy    = !stub && ((div_B == 0) || (m_active && m_cnt == 0));
    div_exc    = (div_B == 0);
    div_result = (div_B == 0) ? '0 : m_q;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        m_e = sb.pop_front();
        check("result",    result,          m_e.res);
        check("exception", 32'(exception),  32'(m_e.exc));
        check("rd_out",    32'(rd_out),     32'(m_e.rd));
        check("timeout",   32'(timeout),    32'(m_e.to));
      end
    end
  end

  // Raise start (it may be held while busy), wait for acceptance, check ISSUE.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] q, input logic exc, input logic to, input bit push);
    int n = 0;
    exp_t e;
    start = 1'b1; dividend_in = a; divisor_in = b; rd_in = rd;
    while (busy === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("accept_timeout", 32'(busy), 32'd0);
    e.res = q; e.exc = exc; e.rd = rd; e.to = to;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("ctrl_div_issue", 32'(ctrl_div), 32'd1);
    check("busy_issue",     32'(busy),     32'd1);
    check("div_A_issue",    div_A,         a);
    check("div_B_issue",    div_B,         b);
  endtask

  // From ISSUE (cycle 1 after the start cycle), wait for done and check latency.
  task automatic wait_done(input int exp_cyc, input logic [31:0] a);
    int cyc = 1;
    int pulses = 0;
    bit held = 1'b1;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ctrl_div === 1'b1) pulses++;
      if (div_A !== a) held = 1'b0;
    end
    check("done_latency",   32'(cyc),    32'(exp_cyc));
    check("ctrl_div_extra", 32'(pulses), 32'd0);
    check("div_A_held",     32'(held),   32'd1);
    check("busy_at_done",   32'(busy),   32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "tb timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    dividend_in = '0; divisor_in = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ctrl_div",  32'(ctrl_div),  32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_div_A",     div_A,          32'd0);
    check("rst_div_B",     div_B,          32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_exception", 32'(exception), 32'd0);
    check("rst_rd_out",    32'(rd_out),    32'd0);
    check("rst_timeout",   32'(timeout),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic op, then idle afterwards.
    issue(32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'd100);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy",      32'(busy), 32'd0);

    // Signed cases; the second is accepted back-to-back in DONE.
    issue(32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFF2, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'hFFFF_FF9C);
    issue(32'h8000_0000, 32'd1, 5'd5, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'h8000_0000);
    issue(32'd7, 32'hFFFF_FF9C, 5'd6, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'd7);

    // Divide by zero, then a clean op clears exception.
    issue(32'd5, 32'd0, 5'd7, 32'd0, 1'b1, 1'b0, 1'b1);
    wait_done(3, 32'd5);
    issue(32'd9, 32'd3, 5'd8, 32'd3, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'd9);
    @(negedge clk);

    // Flush on the 10th WAIT cycle of a long op.
    lat = 20;
    issue(32'd100, 32'd7, 5'd9, 32'd14, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    repeat (30) @(negedge clk);
    check("flush_result_kept", result,          32'd3);
    check("flush_exc_kept",    32'(exception),  32'd0);
    check("flush_rd_kept",     32'(rd_out),     32'd8);
    lat = 4;

    // Flush coinciding with rdy in WAIT: nothing captured.
    issue(32'd50, 32'd5, 5'd10, 32'd10, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_rdy_busy",   32'(busy), 32'd0);
    check("flush_rdy_result", result,    32'd3);
    repeat (3) @(negedge clk);

    // Flush and start together in IDLE: request dropped.
    start = 1'b1; flush = 1'b1; dividend_in = 32'd77; divisor_in = 32'd7; rd_in = 5'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_ctrl", 32'(ctrl_div), 32'd0);
    check("flush_start_busy", 32'(busy),     32'd0);

    // Start pulsed mid-WAIT is ignored; start held into DONE is accepted.
    issue(32'd100, 32'd7, 5'd11, 32'd14, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend_in = 32'd55; divisor_in = 32'd5; rd_in = 5'd12;
    @(negedge clk);
    start = 1'b0;
    check("midwait_div_A", div_A, 32'd100);
    check("midwait_div_B", div_B, 32'd7);
    issue(32'd40, 32'd8, 5'd13, 32'd5, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'd40);
    @(negedge clk);

    // Divider never answers.
    stub = 1'b1;
`ifdef DIV_TIMEOUT_EN
    issue(32'd1, 32'd1, 5'd14, 32'd0, 1'b1, 1'b1, 1'b1);
    wait_done(42, 32'd1);
    stub = 1'b0;
    issue(32'd9, 32'd3, 5'd15, 32'd3, 1'b0, 1'b0, 1'b1);
    wait_done(7, 32'd9);
`else
    issue(32'd1, 32'd1, 5'd14, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    check("hang_busy",    32'(busy),    32'd1);
    check("hang_timeout", 32'(timeout), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    stub  = 1'b0;
    check("hang_flush_busy", 32'(busy), 32'd0);
`endif
    @(negedge clk);

    // Reset mid-op aborts and clears everything.
    issue(32'd100, 32'd7, 5'd16, 32'd14, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",   32'(busy),   32'd0);
    check("mid_rst_div_A",  div_A,       32'd0);
    check("mid_rst_result", result,      32'd0);
    check("mid_rst_rd_out", 32'(rd_out), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
